// File: rtl/buttons_in.sv
// rtl/buttons_in.sv - Avalon-MM push-button input port: sync, debounce, edge capture, maskable irq.
// Optional debouncer enabled by defining BUTTONS_IN_DEBOUNCE_EN; otherwise level is sync delayed one cycle.
module buttons_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             csi_clk,
   input  logic             csi_reset,
   input  logic [3:0]       avs_s1_address,
   input  logic             avs_s1_read,
   output logic [7:0]       avs_s1_readdata,
   input  logic             avs_s1_write,
   input  logic [7:0]       avs_s1_writedata,
   input  logic [WIDTH-1:0] user_datain_0,
   output logic             ins_irq0_irq
);

   logic [WIDTH-1:0] meta_q, sync_q;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] edge_clr;
   logic [7:0]       readdata_q, readdata_d;
   logic             unused_wdata;

   assign wdata        = avs_s1_writedata[WIDTH-1:0];
   assign unused_wdata = ^avs_s1_writedata;

`ifdef BUTTONS_IN_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q [WIDTH];
   logic [CW-1:0] cnt_d [WIDTH];

   // A bit's counter only runs while sync disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_q[i] != level_q[i]) begin
            if (cnt_q[i] == TERM) begin
               level_d[i] = sync_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge csi_clk or posedge csi_reset) begin
      if (csi_reset) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   assign level_d = sync_q;
`endif

   // A rising level in the same cycle as a W1C keeps the bit set.
   assign edge_clr = (avs_s1_write && avs_s1_address == 4'd1) ? wdata : '0;
   assign edge_d   = (edge_q & ~edge_clr) | (level_d & ~level_q);
   assign mask_d   = (avs_s1_write && avs_s1_address == 4'd2) ? wdata : mask_q;

   always_comb begin
      readdata_d = '0;
      case (avs_s1_address)
         4'd0:    readdata_d[WIDTH-1:0] = level_q;
         4'd1:    readdata_d[WIDTH-1:0] = edge_q;
         4'd2:    readdata_d[WIDTH-1:0] = mask_q;
         4'd3:    readdata_d[WIDTH-1:0] = sync_q;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge csi_clk or posedge csi_reset) begin
      if (csi_reset) begin
         meta_q     <= '0;
         sync_q     <= '0;
         level_q    <= '0;
         edge_q     <= '0;
         mask_q     <= '0;
         readdata_q <= '0;
      end else begin
         meta_q  <= user_datain_0;
         sync_q  <= meta_q;
         level_q <= level_d;
         edge_q  <= edge_d;
         mask_q  <= mask_d;
         if (avs_s1_read) begin
            readdata_q <= readdata_d;
         end
      end
   end

   assign avs_s1_readdata = readdata_q;
   assign ins_irq0_irq    = |(edge_q & mask_q);

endmodule

// File: tb/tb_buttons_in.sv
// tb/tb_buttons_in.sv - randomized bench for buttons_in against a cycle-level reference model.
// Follows BUTTONS_IN_DEBOUNCE_EN the same way the design does.
module tb_buttons_in;

   localparam int W = 4;
   localparam int D = 16;
`ifdef BUTTONS_IN_DEBOUNCE_EN
   localparam int LVL = 2 + D;
`else
   localparam int LVL = 3;
`endif

   logic       csi_clk = 1'b0;
   logic       csi_reset = 1'b1;
   logic [3:0] avs_s1_address = '0;
   logic       avs_s1_read = 1'b0;
   logic [7:0] avs_s1_readdata;
   logic       avs_s1_write = 1'b0;
   logic [7:0] avs_s1_writedata = '0;
   logic [3:0] user_datain_0 = '0;
   logic       ins_irq0_irq;

   buttons_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .csi_clk          (csi_clk),
      .csi_reset        (csi_reset),
      .avs_s1_address   (avs_s1_address),
      .avs_s1_read      (avs_s1_read),
      .avs_s1_readdata  (avs_s1_readdata),
      .avs_s1_write     (avs_s1_write),
      .avs_s1_writedata (avs_s1_writedata),
      .user_datain_0    (user_datain_0),
      .ins_irq0_irq     (ins_irq0_irq)
   );

   always #5 csi_clk = ~csi_clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: pin history and register contents as the bus sees them.
   logic [3:0] m_meta = '0, m_sync = '0, m_level = '0, m_edge = '0, m_mask = '0;
   logic [7:0] m_rd = '0;
   logic [3:0] hist[$];
   logic [3:0] cur_pin = '0;

   function automatic logic [7:0] reg_value(input logic [3:0] a);
      case (a)
         4'd0:    return {4'b0, m_level};
         4'd1:    return {4'b0, m_edge};
         4'd2:    return {4'b0, m_mask};
         4'd3:    return {4'b0, m_sync};
         default: return 8'h00;
      endcase
   endfunction

   // Advance the model across one rising edge given the inputs presented to it.
   task automatic model_step(input logic rst, input logic rd, input logic wr,
                             input logic [3:0] a, input logic [7:0] wd, input logic [3:0] pin);
      logic [3:0] nl;
      logic [3:0] clr;
      bit         held;
      if (rst) begin
         m_meta = '0; m_sync = '0; m_level = '0; m_edge = '0; m_mask = '0; m_rd = '0;
         hist.delete();
         return;
      end
`ifdef BUTTONS_IN_DEBOUNCE_EN
      // Accept a new level once sync has shown the opposite value for D samples in a row.
      hist.push_back(m_sync);
      if (hist.size() > D) void'(hist.pop_front());
      nl = m_level;
      if (hist.size() == D) begin
         for (int i = 0; i < W; i++) begin
            held = 1'b1;
            foreach (hist[j]) if (hist[j][i] == m_level[i]) held = 1'b0;
            if (held) nl[i] = ~m_level[i];
         end
      end
`else
      nl = m_sync;
`endif
      if (rd) m_rd = reg_value(a);
      clr    = (wr && a == 4'd1) ? wd[3:0] : 4'b0;
      m_edge = (m_edge & ~clr) | (nl & ~m_level);
      if (wr && a == 4'd2) m_mask = wd[3:0];
      m_level = nl;
      m_sync  = m_meta;
      m_meta  = pin;
   endtask

   // One bus cycle: check outputs at the falling edge, then drive inputs for the next rising edge.
   task automatic cyc(input logic rst, input logic rd, input logic wr,
                      input logic [3:0] a, input logic [7:0] wd, input logic [3:0] pin);
      @(negedge csi_clk);
      check("readdata", avs_s1_readdata, m_rd);
      check("irq", {7'b0, ins_irq0_irq}, {7'b0, |(m_edge & m_mask)});
      csi_reset        = rst;
      avs_s1_read      = rd;
      avs_s1_write     = wr;
      avs_s1_address   = a;
      avs_s1_writedata = wd;
      user_datain_0    = pin;
      cur_pin          = pin;
      model_step(rst, rd, wr, a, wd, pin);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, cur_pin);
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
      cyc(1'b0, 1'b0, 1'b1, a, d, cur_pin);
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [7:0] v);
      cyc(1'b0, 1'b1, 1'b0, a, 8'h00, cur_pin);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, cur_pin);
      v = avs_s1_readdata;
   endtask

   logic [7:0] v;
   logic [7:0] res  [0:31];
   logic       irqs [0:31];

   initial begin
      // Reset held while pins and bus are active.
      for (int i = 0; i < 6; i++)
         cyc(1'b1, 1'b1, 1'b1, 4'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'b0000);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'b0000);
      for (int a = 0; a < 4; a++) begin
         rd_reg(4'(a), v);
         check($sformatf("reset_reg%0d", a), v, 8'h00);
      end
      check("reset_irq", {7'b0, ins_irq0_irq}, 8'h00);

      // Clean press of bit 0 with its interrupt enabled.
      wr_reg(4'd2, 8'h01);
      idle(2);
      for (int k = 1; k <= LVL + 2; k++) begin
         cyc(1'b0, 1'b1, 1'b0, (k == 2 || k == 3) ? 4'd3 : 4'd0, 8'h00, 4'b0001);
         res[k-1]  = avs_s1_readdata;
         irqs[k-1] = ins_irq0_irq;
      end
      check("raw_before", res[2], 8'h00);
      check("raw_after", res[3], 8'h01);
      if (LVL >= 4) check("data_before", res[LVL], 8'h00);
      check("data_after", res[LVL+1], 8'h01);
      check("irq_before", {7'b0, irqs[LVL-1]}, 8'h00);
      check("irq_at_edge", {7'b0, irqs[LVL]}, 8'h01);
      rd_reg(4'd1, v);
      check("edge_press", v, 8'h01);

      // W1C of one bit out of two.
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'b0000);
      idle(LVL + 3);
      wr_reg(4'd1, 8'hFF);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'b0011);
      idle(LVL + 2);
      rd_reg(4'd1, v);
      check("edge_two", v, 8'h03);
      wr_reg(4'd1, 8'h01);
      rd_reg(4'd1, v);
      check("edge_w1c", v, 8'h02);

      // W1C landing on the very edge where level[1] rises again.
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'b0000);
      idle(LVL + 3);
      wr_reg(4'd1, 8'hFF);
      rd_reg(4'd1, v);
      check("edge_cleared", v, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'b0010);
      idle(LVL - 2);
      wr_reg(4'd1, 8'h02);
      rd_reg(4'd1, v);
      check("edge_priority", v, 8'h02);
      rd_reg(4'd0, v);
      check("data_priority", v, 8'h02);

      // Mask gating.
      wr_reg(4'd2, 8'h00);
      idle(1);
      check("irq_masked", {7'b0, ins_irq0_irq}, 8'h00);
      wr_reg(4'd2, 8'h02);
      idle(1);
      check("irq_unmasked", {7'b0, ins_irq0_irq}, 8'h01);
      wr_reg(4'd1, 8'h02);
      idle(1);
      check("irq_cleared", {7'b0, ins_irq0_irq}, 8'h00);

      // Random pins (bouncy and stable), random bus traffic, one reset mid-run.
      begin
         int       hold;
         int       op;
         logic [3:0] pin;
         hold = 0;
         pin  = cur_pin;
         for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
               pin  = pin ^ 4'($urandom);
               hold = ($urandom_range(0, 2) == 0) ? $urandom_range(D, 3 * D) : $urandom_range(1, 6);
            end
            hold--;
            op = $urandom_range(0, 99);
            if (c >= 2000 && c < 2004)
               cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, pin);
            else if (op < 35)
               cyc(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 8'h00, pin);
            else if (op < 50)
               cyc(1'b0, 1'b0, 1'b1, ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15))
                                                                  : 4'($urandom_range(0, 3)),
                   8'($urandom), pin);
            else if (op < 53)
               cyc(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 3)), 8'($urandom), pin);
            else
               cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, pin);
         end
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/buttons_in.md
# buttons_in

Avalon-MM slave input port that samples the watch push-buttons, synchronises and debounces them, and exposes the debounced level, a rising-edge capture register and a maskable interrupt to the Nios II CPU. It is the read-side counterpart of the LED output port. It sits on the same 8-bit Avalon bus and clock domain, and its external pins come directly from the board buttons.

## Interface
- WIDTH, 4: number of button inputs; legal range 1..8.
- DEBOUNCE_CYCLES, 50000: number of consecutive csi_clk cycles a synchronised input must hold a new value before it is accepted; legal minimum 2.

- csi_clk  input  1  clock.
- csi_reset  input  1  reset; asynchronous, active-high.
- avs_s1_address  input  4  register select.
- avs_s1_read  input  1  read strobe.
- avs_s1_readdata  output  8  read data; fixed read latency 1.
- avs_s1_write  input  1  write strobe.
- avs_s1_writedata  input  8  write data.
- user_datain_0  input  WIDTH  raw button pins, asynchronous, active-high (pressed = 1).
- ins_irq0_irq  output  1  level interrupt to CPU.

## Operation
- Synchroniser: two flops per bit on user_datain_0 produce sync[WIDTH-1:0].
- Debouncer: one counter per bit, width clog2(DEBOUNCE_CYCLES).
  - When sync[i] == level[i], the counter is held at 0.
  - When they differ, the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and they still differ, level[i] takes sync[i] and the counter returns to 0.
  - A return to agreement before the terminal count clears the counter; no change is accepted.
- Edge capture: edge[i] is set on any cycle where level[i] goes 0->1, and it is sticky.
- Register map (byte addresses; bits above WIDTH read 0, writes to them are ignored):
  - 0 DATA, RO: level.
  - 1 EDGE, R/W1C: writing 1 to a bit clears it; writing 0 has no effect.
  - 2 MASK, R/W: interrupt enable per bit.
  - 3 RAW, RO: sync (post-synchroniser, pre-debounce).
  - 4..15: read 0; writes ignored.
- Interrupt: ins_irq0_irq = |(edge & mask). It is driven from registered state only, so it is glitch-free.
- Write/set priority: if a W1C of edge[i] and a new rising edge on level[i] occur in the same cycle, the set wins and edge[i] = 1.
- avs_s1_read and avs_s1_write are never asserted together (bus guarantee). If they are, the write is performed and readdata is updated as for the read.
- Reset values: sync, level, counters, edge and mask = 0; avs_s1_readdata = 0; ins_irq0_irq = 0.
- Reset asserted mid-debounce discards the count. After release, level is re-acquired from 0.

## Timing
- Pin to sync: 2 cycles.
- Sync change to level change: DEBOUNCE_CYCLES cycles after the first differing sync value, for a stable input.
- level rise to edge set: the same edge on which level rises, so edge and level update together.
- edge set to irq high: combinational from edge/mask, so it is high in the same cycle edge reads 1.
- Read: address is sampled with avs_s1_read at clock edge N. avs_s1_readdata is valid after edge N and held until the next read. The value returned is the register contents before any write in cycle N.
- Write: takes effect at the edge on which avs_s1_write is sampled. A read in the following cycle returns the new value.

## Configuration
- BUTTONS_IN_DEBOUNCE_EN defined:
  - Debouncer is present as described.
  - DATA returns level.
- BUTTONS_IN_DEBOUNCE_EN undefined:
  - Counters are removed and level = sync, registered, so DATA lags RAW by one cycle.
  - Edge detection operates on that level.
  - DEBOUNCE_CYCLES is ignored.
- Register map, reset and bus timing are identical in both builds.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=16, debounce enabled unless stated.

- Reset: hold csi_reset during activity -> after release, reads of addresses 0..3 return 0x00 and ins_irq0_irq = 0.
- Clean press: drive user_datain_0=4'b0001 -> RAW=0x01 two cycles later; DATA=0x01 exactly 16 cycles after RAW changes; EDGE=0x01; with MASK=0x01, irq goes high in the same cycle EDGE sets.
- Bounce: toggle bit 2 every 5 cycles for 60 cycles, then hold 0 -> DATA bit 2 never sets; EDGE stays 0x00.
- W1C and priority: with EDGE=0x03, write 0x01 to address 1 -> EDGE=0x02. Then issue a W1C of bit 1 in the cycle level[1] rises again -> EDGE bit 1 remains 1.
- Mask: EDGE=0x08 with MASK=0x00 -> irq=0. Write MASK=0x08 -> irq=1 the next cycle. Write 0x08 to EDGE -> irq=0.
- Debounce disabled: rebuild without BUTTONS_IN_DEBOUNCE_EN and pulse bit 1 high for 3 cycles -> DATA bit 1 high for 3 cycles, 3 cycles after the pin; EDGE=0x02.
